bcd_digit_converter: RTL and testbench
======================================

# bcd_digit_converter

Sequential binary-to-BCD converter that feeds the board's seven-segment decoders. It accepts a binary value (score, count or timer) on a start strobe and runs a shift-and-add-3 (double-dabble) conversion, one bit per clock. It then presents DIGITS packed 4-bit BCD nibbles, one nibble per seven-segment decoder instance. Out-of-range values are reported by forcing every digit to 4'hE, which the downstream decoder shows as "E".

## Interface
- BIN_W, default 14: binary input width; must satisfy 2^BIN_W ≥ 10^DIGITS.
- DIGITS, default 4: number of BCD digits produced.
- clk  input  1: system clock, all state on rising edge.
- rst  input  1: asynchronous, active-high reset.
- start  input  1: request conversion of bin_in; sampled only in IDLE.
- bin_in  input  BIN_W: unsigned binary value, captured on the accepting edge.
- busy  output  1: high while a conversion is in progress (state ≠ IDLE).
- done  output  1: one-cycle pulse when bcd/overflow are updated.
- overflow  output  1: last conversion had bin_in > 10^DIGITS−1; held until next completion.
- bcd  output  4*DIGITS: packed digits, bcd[3:0] = ones, bcd[7:4] = tens, and so on; held between completions.

## Operation
- States: IDLE, CONVERT, DONE.
- IDLE, start=1:
  - capture bin_in into shift register sh;
  - clear BCD scratch sc (4*DIGITS bits);
  - load bit counter cnt=BIN_W;
  - latch ovf_pend = (bin_in > 10^DIGITS−1);
  - go to CONVERT.
- IDLE, start=0: remain in IDLE.
- CONVERT, each cycle:
  - every scratch nibble ≥5 gets +3 (4-bit result, no carry out of the nibble);
  - then {sc,sh} shifts left by one;
  - cnt decrements.
  - When the shift with cnt=1 is done, go to DONE.
- DONE, one cycle:
  - bcd ← ovf_pend ? all nibbles 4'hE : sc;
  - overflow ← ovf_pend;
  - done ← 1 on the same edge;
  - go to IDLE.
- start while busy=1 is ignored and not queued.
- done is registered; it is 0 in every cycle except the one after the DONE-state edge.
- Reset (asynchronous, any state):
  - state=IDLE;
  - bcd=0 (all digits display 0);
  - busy=0, done=0, overflow=0;
  - sh, sc, cnt, ovf_pend cleared.
  - A conversion interrupted by reset produces no done pulse, and bcd stays 0.

## Timing
- Start accepted at edge E0. CONVERT occupies edges E1..E_BIN_W, one shift per edge.
- bcd, overflow and done update at edge E_(BIN_W+1). Latency is BIN_W+1 cycles (15 at default).
- busy rises after E0 and falls after E_(BIN_W+1), in the same cycle that done is high.
- start asserted in the done cycle is accepted, since the state is IDLE. Back-to-back throughput is one conversion per BIN_W+1 cycles.
- bcd never shows partial results. The downstream decoder sees a stable value except at the single update edge.

## Structure
- Shared package bcd_conv_pkg holds:
  - state enum {IDLE, CONVERT, DONE};
  - constant DIGIT_ERR = 4'hE;
  - constant function max_value(DIGITS) = 10^DIGITS−1.
- One sub-module, bcd_add3: 4-bit combinational correction cell (in ≥5 ? in+3 : in), instantiated DIGITS times in a generate loop.
- Top-level integration: bcd[4k+3:4k] drives seven-segment decoder instance k. No other logic sits between them.

## Test plan
- bin_in=0, start pulse → after 15 cycles done=1, bcd=16'h0000, overflow=0, busy low the following cycle.
- bin_in=9999 → bcd=16'h9999, overflow=0. Then bin_in=1234 → bcd=16'h1234; bcd holds 16'h9999 throughout the second conversion.
- bin_in=10000 → bcd=16'hEEEE, overflow=1. Then bin_in=7 → bcd=16'h0007, overflow clears on that done.
- start re-pulsed with bin_in=5555 at cycles 3 and 10 of a conversion of 42 → single done, bcd=16'h0042. Then start in the done cycle with 5555 → accepted, bcd=16'h5555 15 cycles later.
- rst asserted mid-conversion (cycle 6) → outputs clear immediately (bcd=0, busy=0) with no done. A new start after release converts normally.
- Sweep bin_in 0..9999 against a reference model → exact bcd match, done exactly once per start, latency always 15.

Source files
------------

// File: rtl/bcd_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_conv_pkg
// Brief    : Shared types and constants for the binary-to-BCD digit converter.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_ERR = 4'hE;

  // Largest value representable in the given number of decimal digits.
  function automatic int unsigned max_value(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add3
// Brief    : Double-dabble correction cell: adds 3 to a nibble of 5 or more.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule
`default_nettype wire

// File: rtl/bcd_digit_converter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_converter
// Brief    : Sequential shift-and-add-3 binary-to-BCD converter, one bit/clock.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_converter
  import bcd_conv_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int               c_bcd_w = 4 * DIGITS;
  localparam int               c_cnt_w = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] c_max   = BIN_W'(max_value(DIGITS));

  state_t               r_state;
  state_t               w_next;
  logic [BIN_W-1:0]     r_sh;
  logic [c_bcd_w-1:0]   r_sc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_ovf_pend;
  logic [c_bcd_w-1:0]   r_bcd;
  logic                 r_done;
  logic                 r_overflow;
  logic [c_bcd_w-1:0]   w_adj;
  logic                 w_ovf;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
      bcd_add3 u_add3 (
        .i_nib (r_sc[4*k+3:4*k]),
        .o_nib (w_adj[4*k+3:4*k])
      );
    end
  endgenerate

  assign w_ovf = (bin_in > c_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CONVERT;
      CONVERT: if (r_cnt == c_cnt_w'(1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Scratch is corrected before the shift, so {sc,sh} moves left as one word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh       <= '0;
      r_sc       <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sh       <= bin_in;
            r_sc       <= '0;
            r_cnt      <= c_cnt_w'(BIN_W);
            r_ovf_pend <= w_ovf;
          end
        end
        CONVERT: begin
          r_sc  <= {w_adj[c_bcd_w-2:0], r_sh[BIN_W-1]};
          r_sh  <= {r_sh[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt - c_cnt_w'(1);
        end
        DONE: begin
          r_bcd      <= r_ovf_pend ? {DIGITS{DIGIT_ERR}} : r_sc;
          r_overflow <= r_ovf_pend;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign overflow = r_overflow;
  assign bcd      = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_digit_converter
// Brief    : Self-checking bench for bcd_digit_converter against a decimal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_digit_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] bcd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_digit_converter #(.BIN_W(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd      (bcd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal digits by division; anything beyond four digits shows as all-E.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int          p;
    r = '0;
    if (v > 9999) return 16'hEEEE;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // launch=0 means start/bin_in were already raised in the previous done cycle.
  task automatic do_conv(input int v, input bit launch, input bit inject,
                         input bit b2b, input int v2);
    logic [15:0] held;
    bit          held_ok;
    int          lat;
    held    = bcd;
    held_ok = 1'b1;
    lat     = 0;
    if (launch) begin
      start  = 1'b1;
      bin_in = 14'(v);
    end
    tick;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("done_low_after_start", {31'd0, done}, 32'd0);
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (done) begin
        lat = c;
        break;
      end
      if (bcd !== held) held_ok = 1'b0;
      if (inject && (c == 3 || c == 10)) begin
        start  = 1'b1;
        bin_in = 14'd5555;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", lat, 15);
    check("bcd_held", {31'd0, held_ok}, 32'd1);
    check("bcd", {16'd0, bcd}, {16'd0, ref_bcd(v)});
    check("overflow", {31'd0, overflow}, (v > 9999) ? 32'd1 : 32'd0);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    if (b2b) begin
      start  = 1'b1;
      bin_in = 14'(v2);
    end else begin
      tick;
      check("done_single", {31'd0, done}, 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int  vals[6];
    bit  seen;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bcd", {16'd0, bcd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick;

    do_conv(0, 1'b1, 1'b0, 1'b0, 0);
    do_conv(9999, 1'b1, 1'b0, 1'b0, 0);
    do_conv(1234, 1'b1, 1'b0, 1'b0, 0);
    do_conv(10000, 1'b1, 1'b0, 1'b0, 0);
    do_conv(7, 1'b1, 1'b0, 1'b0, 0);
    do_conv(42, 1'b1, 1'b1, 1'b1, 5555);
    do_conv(5555, 1'b0, 1'b0, 1'b0, 0);

    // Reset in the middle of a conversion.
    start  = 1'b1;
    bin_in = 14'd3333;
    tick;
    start = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    #1;
    check("midrst_bcd", {16'd0, bcd}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_ovf", {31'd0, overflow}, 32'd0);
    tick;
    tick;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick;
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", {31'd0, seen}, 32'd0);
    check("midrst_bcd_hold", {16'd0, bcd}, 32'd0);
    do_conv(4321, 1'b1, 1'b0, 1'b0, 0);

    vals = '{9998, 9999, 10000, 16383, 1, 10};
    foreach (vals[i]) do_conv(vals[i], 1'b1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 300; i++) begin
      do_conv(int'($urandom_range(0, 16383)), 1'b1, 1'b0, 1'b0, 0);
    end
    for (int i = 0; i < 100; i++) begin
      do_conv(int'($urandom_range(0, 9999)), 1'b1, 1'b0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
